// File: rtl/jump_input_conditioner_if.sv
// rtl/jump_input_conditioner_if.sv - key input and jump/tick outputs of the jump input conditioner
//
// Purpose: groups the board-key input and the conditioned game-side outputs.
// Signals:
//   key_in      raw asynchronous push-button level
//   frame_tick  one-cycle pulse once per frame
//   input_jump  frame-aligned jump request level
//   jump_press  one-cycle pulse when input_jump first rises for a press
// Modports:
//   master  drives key_in, observes the outputs (board / testbench side)
//   slave   receives key_in, drives the outputs (conditioner side)
interface jump_input_conditioner_if;
  logic key_in;
  logic frame_tick;
  logic input_jump;
  logic jump_press;

  modport master (
    output key_in,
    input  frame_tick,
    input  input_jump,
    input  jump_press
  );

  modport slave (
    input  key_in,
    output frame_tick,
    output input_jump,
    output jump_press
  );
endinterface

// File: rtl/jump_input_conditioner.sv
// rtl/jump_input_conditioner.sv - debounced, frame-aligned jump request generator with frame tick
//
// Purpose: synchronises and debounces the jump key, divides the clock into a
// frame tick and converts each distinct press into one bounded jump request.
// Ports:
//   clock_i  system clock, rising edge
//   reset_i  asynchronous active-low reset
//   jic_if   slave side of jump_input_conditioner_if
//            (key_in in; frame_tick, input_jump, jump_press out)
module jump_input_conditioner #(
  parameter int CLOCK_DIV       = 833333,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_HOLD_FRAMES = 12,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  jump_input_conditioner_if.slave  jic_if
);

  localparam int DIV_W  = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (MAX_HOLD_FRAMES > 0) ? $clog2(MAX_HOLD_FRAMES + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLOCK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_HOLD,
    ST_LOCKOUT
  } state_t;

  // Normalise so that 1 always means pressed.
  logic pressed_raw;
  assign pressed_raw = (KEY_ACTIVE_LOW != 0) ? ~jic_if.key_in : jic_if.key_in;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; reset value 0 reads as released.
  // ---------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pressed_raw;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: the stable bit follows the synchronised key only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  // ---------------------------------------------------------------------------
  logic            db_q;
  logic            db_d;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            db_prev_q;
  logic            db_rise;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d     = ~db_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      db_q      <= 1'b0;
      db_cnt_q  <= '0;
      db_prev_q <= 1'b0;
    end else begin
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      db_prev_q <= db_q;
    end
  end

  assign db_rise = db_q & ~db_prev_q;

  // ---------------------------------------------------------------------------
  // Free-running frame divider.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             frame_tick;

  assign frame_tick = (div_cnt_q == DIV_LAST);
  assign div_cnt_d  = frame_tick ? '0 : div_cnt_q + DIV_W'(1);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Press state machine. A rising edge of the debounced key arms a jump that
  // is launched on the next frame tick, so even a tap released before the
  // tick still produces one frame of input_jump. Further presses are ignored
  // until the key has been seen released at a tick (HOLD) or in LOCKOUT.
  // ---------------------------------------------------------------------------
  state_t            state_q;
  state_t            state_d;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic              input_jump_q;
  logic              input_jump_d;
  logic              jump_press_q;
  logic              jump_press_d;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    input_jump_d = input_jump_q;
    jump_press_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        input_jump_d = 1'b0;
        // A press coinciding with a tick only arms; the jump waits a full frame.
        if (db_rise) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (frame_tick) begin
          state_d      = ST_HOLD;
          input_jump_d = 1'b1;
          jump_press_d = 1'b1;
          hold_cnt_d   = HOLD_W'(1);
        end
      end

      ST_HOLD: begin
        // The key is only inspected at ticks, so a quick release-repress
        // between two ticks does not end the hold.
        if (frame_tick) begin
          if (!db_q) begin
            state_d      = ST_IDLE;
            input_jump_d = 1'b0;
          end else if (hold_cnt_q == HOLD_MAX) begin
            state_d      = ST_LOCKOUT;
            input_jump_d = 1'b0;
          end else begin
            hold_cnt_d   = hold_cnt_q + HOLD_W'(1);
            input_jump_d = 1'b1;
          end
        end
      end

      ST_LOCKOUT: begin
        input_jump_d = 1'b0;
        if (!db_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        input_jump_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      input_jump_q <= 1'b0;
      jump_press_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      input_jump_q <= input_jump_d;
      jump_press_q <= jump_press_d;
    end
  end

  assign jic_if.frame_tick = frame_tick;
  assign jic_if.input_jump = input_jump_q;
  assign jic_if.jump_press = jump_press_q;

endmodule

// File: tb/tb_jump_input_conditioner.sv
// tb/tb_jump_input_conditioner.sv - scoreboard bench for jump_input_conditioner
module tb_jump_input_conditioner;

  localparam int EV_RISE  = 0;
  localparam int EV_PRESS = 1;
  localparam int EV_FALL  = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  logic prev_jump;
  ev_t  exp_q[$];

  jump_input_conditioner_if u_if ();

  jump_input_conditioner #(
    .CLOCK_DIV       (8),
    .DEBOUNCE_CYCLES (4),
    .MAX_HOLD_FRAMES (3),
    .KEY_ACTIVE_LOW  (1)
  ) u_dut (
    .clock_i (clock),
    .reset_i (reset),
    .jic_if  (u_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter: edge n is the n-th rising edge after reset release.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic observe(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d, expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind %0d at edge %0d, expected kind %0d at edge %0d",
                 kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: samples between edges, checks the tick phase every cycle and
  // turns every input_jump edge and jump_press cycle into a scoreboard event.
  always @(negedge clock) begin
    if (!reset) begin
      prev_jump = 1'b0;
    end else begin
      check_bit("frame_tick", u_if.frame_tick, (cyc % 8) == 7);
      if (u_if.input_jump !== prev_jump) begin
        observe(u_if.input_jump ? EV_RISE : EV_FALL);
        prev_jump = u_if.input_jump;
      end
      if (u_if.jump_press === 1'b1) observe(EV_PRESS);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    prev_jump = 1'b0;
    reset     = 1'b0;
    u_if.key_in = 1'b1;
    #22;
    reset = 1'b1;
    #1;
    check_bit("reset_frame_tick", u_if.frame_tick, 1'b0);
    check_bit("reset_input_jump", u_if.input_jump, 1'b0);
    check_bit("reset_jump_press", u_if.jump_press, 1'b0);

    // Idle key: no events, tick phase checked by the monitor.
    wait_edge(40);

    // Bounce: 3-cycle presses never reach the 4-cycle debounce.
    for (int i = 0; i < 5; i++) begin
      u_if.key_in = 1'b0;
      wait_edge(40 + 6 * i + 3);
      u_if.key_in = 1'b1;
      wait_edge(40 + 6 * i + 6);
    end

    // Long hold: db up at 86, armed 87, jump 88..112, then lockout.
    wait_edge(80);
    push_ev(EV_RISE, 88);
    push_ev(EV_PRESS, 88);
    push_ev(EV_FALL, 112);
    u_if.key_in = 1'b0;
    wait_edge(180);
    u_if.key_in = 1'b1;

    // Re-press after release: release seen at tick 224 (db fell at 218).
    wait_edge(200);
    push_ev(EV_RISE, 208);
    push_ev(EV_PRESS, 208);
    push_ev(EV_FALL, 224);
    u_if.key_in = 1'b0;
    wait_edge(212);
    u_if.key_in = 1'b1;

    // Tap of 6 cycles: exactly one frame 248..256.
    wait_edge(240);
    push_ev(EV_RISE, 248);
    push_ev(EV_PRESS, 248);
    push_ev(EV_FALL, 256);
    u_if.key_in = 1'b0;
    wait_edge(246);
    u_if.key_in = 1'b1;

    // db_rise in the tick cycle after edge 271: arm at 272, jump at 280.
    wait_edge(265);
    push_ev(EV_RISE, 280);
    push_ev(EV_PRESS, 280);
    push_ev(EV_FALL, 288);
    u_if.key_in = 1'b0;
    wait_edge(281);
    u_if.key_in = 1'b1;

    // Reset mid-hold: jump at 312, hold_cnt 2 after 320, reset after 322.
    wait_edge(300);
    push_ev(EV_RISE, 312);
    push_ev(EV_PRESS, 312);
    u_if.key_in = 1'b0;
    wait_edge(322);
    check_bit("hold_before_reset", u_if.input_jump, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_bit("async_reset_input_jump", u_if.input_jump, 1'b0);
    check_bit("async_reset_jump_press", u_if.jump_press, 1'b0);
    check_bit("async_reset_frame_tick", u_if.frame_tick, 1'b0);
    u_if.key_in = 1'b1;
    #20;
    reset = 1'b1;

    // After reset: idle until a fresh press; press at edge 20 -> jump 32..48.
    wait_edge(20);
    push_ev(EV_RISE, 32);
    push_ev(EV_PRESS, 32);
    push_ev(EV_FALL, 48);
    u_if.key_in = 1'b0;
    wait_edge(40);
    u_if.key_in = 1'b1;
    wait_edge(60);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      while (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        $display("FAIL missing_event: got none, expected kind %0d at edge %0d", e.kind, e.cyc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jump_input_conditioner.md
# jump_input_conditioner

Converts the raw, bouncing jump push-button into the clean, frame-aligned `input_jump` level consumed by the vertical motion FSM. It also generates the frame tick that paces the game logic. The block synchronises and debounces the key, then turns each distinct press into one jump request. That request is held for at most `MAX_HOLD_FRAMES` frames and is not repeated until the key is released. It sits between the board key pin and the vertical motion FSM.

## Interface
- `CLOCK_DIV`, 833333: clock cycles per frame tick (60 Hz at 50 MHz); must be at least 2.
- `DEBOUNCE_CYCLES`, 500000: cycles the synchronised key must differ from the debounced state before the change is accepted; must be at least 1.
- `MAX_HOLD_FRAMES`, 12: maximum number of frames `input_jump` stays high for one press.
- `KEY_ACTIVE_LOW`, 1: when 1, `key_in`=0 means pressed.

Ports:
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `key_in`  in  1  raw asynchronous push-button.
- `frame_tick`  out  1  one-cycle pulse once every `CLOCK_DIV` cycles.
- `input_jump`  out  1  jump request level, frame-aligned.
- `jump_press`  out  1  one-cycle pulse on the cycle `input_jump` first rises for a press.

## Operation
- **Normalise:** `pressed_raw = KEY_ACTIVE_LOW ? ~key_in : key_in`.
- **Synchroniser:** two flops; both reset to 0, meaning released.
- **Debounce:**
  - Stable bit `db` resets to 0; counter `db_cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits and resets to 0.
  - If `sync2 != db`: `db_cnt` increments. When `db_cnt == DEBOUNCE_CYCLES-1`, `db` toggles and `db_cnt` clears.
  - If `sync2 == db`: `db_cnt` clears.
  - `db_rise` = `db` is 1 now and was 0 on the previous cycle (registered copy of `db`).
- **Frame divider:**
  - `div_cnt` counts 0..`CLOCK_DIV-1`, wraps to 0 and runs freely; it resets to 0.
  - `frame_tick = (div_cnt == CLOCK_DIV-1)`.
- **State machine:** states IDLE, ARMED, HOLD, LOCKOUT; resets to IDLE. `hold_cnt` is `$clog2(MAX_HOLD_FRAMES+1)` bits and resets to 0.
  - IDLE: `db_rise` → ARMED.
  - ARMED: on `frame_tick` → HOLD; set `input_jump`=1, `jump_press`=1, `hold_cnt`=1. A press released before the tick still yields the jump (a tap is never lost).
  - HOLD, on `frame_tick`:
    - `db`=0 → IDLE, `input_jump`=0.
    - else `hold_cnt == MAX_HOLD_FRAMES` → LOCKOUT, `input_jump`=0.
    - else `hold_cnt` increments and `input_jump` stays 1.
  - LOCKOUT: `input_jump`=0; `db`=0 → IDLE on the next edge, with no tick needed.
- **Presses ignored:** `db_rise` in ARMED, HOLD or LOCKOUT is ignored. A release-and-repress entirely between two ticks during HOLD is invisible, and the hold continues.
- **`jump_press`:** registered, high for exactly one cycle; it clears on the next edge.
- **Simultaneous events:** `db_rise` in the same cycle as `frame_tick` while in IDLE → ARMED only; HOLD starts at the next tick.

## Timing
- **Reset values:** `frame_tick` reads 0 (`div_cnt`=0), `input_jump`=0, `jump_press`=0. All registers clear asynchronously. Reset asserted mid-HOLD drops `input_jump` immediately.
- **Debounce latency:** with `key_in` pressed and stable before edge k, `db` rises at edge k+1+`DEBOUNCE_CYCLES`, and ARMED is entered at edge k+2+`DEBOUNCE_CYCLES`.
- **Jump latency:** `input_jump` and `jump_press` rise at the edge that ends the first `frame_tick` cycle after ARMED. The wait is between 1 and `CLOCK_DIV` cycles after entering ARMED.
- **Changes:** `input_jump` changes only at tick-ending edges, except for reset.
- **First tick:** after reset release, the first `frame_tick` is high during the cycle following edge `CLOCK_DIV-1`.
- **Bounce glitches:** any glitch shorter than `DEBOUNCE_CYCLES` cycles produces no change.

## Test plan
Use `CLOCK_DIV`=8, `DEBOUNCE_CYCLES`=4, `MAX_HOLD_FRAMES`=3, `KEY_ACTIVE_LOW`=1 for all scenarios.
- **Reset and tick rate:** `reset`=0 then released; `key_in`=1 → `input_jump`=0 and `jump_press`=0 throughout. `frame_tick` is high for 1 cycle in every 8, first after edge 7.
- **Bounce rejection:** `key_in` pulses low for 3 cycles, 5 times with 3-cycle gaps → `db` never rises and `input_jump` stays 0.
- **Long hold:** `key_in`=0 held for 100 cycles → `jump_press` pulses once. `input_jump` is high for exactly 3 frames (24 cycles), then 0 in LOCKOUT with no re-jump. Release, then press again → a new jump.
- **Tap:** `key_in` low for 6 cycles, with the release before the next tick → `input_jump` high for exactly 1 frame, then IDLE.
- **Simultaneous press and tick:** `db_rise` coincides with `frame_tick` → `input_jump` rises at the end of the following tick, 8 cycles later.
- **Reset mid-hold:** in HOLD with `hold_cnt`=2, `reset`=0 → `input_jump`=0 asynchronously. After release, the state is IDLE and a held key needs a fresh release-press.
